// File: rtl/icache_sa_pkg.sv
// Shared types and helpers for the set-associative instruction cache:
// FSM states, width helpers and tree pseudo-LRU walk functions.
package icache_sa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_MISS_REQ,
    ST_REFILL,
    ST_RESPOND,
    ST_FLUSH
  } state_e;

  function automatic int woff_bits(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int tag_bits(input int addr_width, input int index_bits, input int words_per_line);
    return addr_width - index_bits - $clog2(words_per_line) - 2;
  endfunction

  function automatic int way_bits(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  // Tree nodes are heap-ordered (children of n at 2n+1, 2n+2); a set bit steers the victim right.
  function automatic logic [2:0] plru_victim(input logic [6:0] bits, input logic [1:0] levels);
    logic [2:0] node;
    logic [2:0] way;
    node = '0;
    way  = '0;
    for (int l = 0; l < 3; l++) begin
      if (2'(l) < levels) begin
        way  = {way[1:0], bits[node]};
        node = {node[1:0], 1'b0} + (bits[node] ? 3'd2 : 3'd1);
      end
    end
    return way;
  endfunction

  function automatic logic [6:0] plru_touch(input logic [6:0] bits, input logic [2:0] way,
                                            input logic [1:0] levels);
    logic [6:0] res;
    logic [2:0] node;
    logic [2:0] sh;
    logic       dir;
    res  = bits;
    node = '0;
    sh   = way;
    for (int l = 0; l < 3; l++) begin
      if (2'(l) < levels) begin
        dir       = sh[levels - 2'd1];
        res[node] = ~dir;
        node      = {node[1:0], 1'b0} + (dir ? 3'd2 : 3'd1);
        sh        = {sh[1:0], 1'b0};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/icache_plru.sv
// Per-set tree pseudo-LRU state with a clear-set port, a touch port and a
// combinational victim output for the set being looked up.
module icache_plru
  import icache_sa_pkg::*;
#(
  parameter int INDEX_BITS    = 4,
  parameter int ASSOCIATIVITY = 2,
  parameter int WAY_BITS      = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_en,
  input  logic [INDEX_BITS-1:0] clr_idx,
  input  logic                  touch_en,
  input  logic [INDEX_BITS-1:0] touch_idx,
  input  logic [WAY_BITS-1:0]   touch_way,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic [WAY_BITS-1:0]   victim
);

  localparam int NUM_SETS = 1 << INDEX_BITS;

  generate
    if (ASSOCIATIVITY == 1) begin : g_direct
      logic unused_plru_inputs;
      assign unused_plru_inputs = ^{clk, rst_n, clr_en, clr_idx, touch_en, touch_idx,
                                    touch_way, rd_idx};
      assign victim = '0;
    end else begin : g_tree
      localparam int         PB  = ASSOCIATIVITY - 1;
      localparam logic [1:0] LVL = 2'($clog2(ASSOCIATIVITY));

      logic [PB-1:0] plru_q [NUM_SETS];
      logic [PB-1:0] plru_d [NUM_SETS];

      always_comb begin
        plru_d = plru_q;
        if (clr_en) begin
          plru_d[clr_idx] = '0;
        end
        if (touch_en) begin
          plru_d[touch_idx] = PB'(plru_touch(7'(plru_q[touch_idx]), 3'(touch_way), LVL));
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int s = 0; s < NUM_SETS; s++) begin
            plru_q[s] <= '0;
          end
        end else begin
          plru_q <= plru_d;
        end
      end

      assign victim = WAY_BITS'(plru_victim(7'(plru_q[rd_idx]), LVL));
    end
  endgenerate

endmodule

// File: rtl/icache_sa_line_cache.sv
// Set-associative instruction cache: parallel tag compare, tree-PLRU victim
// choice, line refill from memory and a set-by-set whole-cache flush.
module icache_sa_line_cache
  import icache_sa_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int WORD_WIDTH     = 32,
  parameter int INDEX_BITS     = 4,
  parameter int WORDS_PER_LINE = 4,
  parameter int ASSOCIATIVITY  = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  rsp_valid,
  output logic [WORD_WIDTH-1:0] rsp_data,
  output logic                  rsp_hit,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_rsp_valid,
  input  logic [WORD_WIDTH-1:0] mem_rsp_data,
  input  logic                  flush,
  output logic                  flush_done
);

  localparam int NUM_SETS  = 1 << INDEX_BITS;
  localparam int WOFF_BITS = woff_bits(WORDS_PER_LINE);
  localparam int TAG_BITS  = tag_bits(ADDR_WIDTH, INDEX_BITS, WORDS_PER_LINE);
  localparam int WAY_BITS  = way_bits(ASSOCIATIVITY);

  state_e                    state_q, state_d;
  logic [TAG_BITS-1:0]       req_tag_q, req_tag_d;
  logic [INDEX_BITS-1:0]     req_idx_q, req_idx_d;
  logic [WOFF_BITS-1:0]      req_woff_q, req_woff_d;
  logic [WAY_BITS-1:0]       victim_q, victim_d;
  logic [WOFF_BITS-1:0]      beat_cnt_q, beat_cnt_d;
  logic [INDEX_BITS-1:0]     flush_idx_q, flush_idx_d;
  logic                      flush_pending_q, flush_pending_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [WORD_WIDTH-1:0]     rsp_data_q, rsp_data_d;
  logic                      rsp_hit_q, rsp_hit_d;
  logic                      mem_req_valid_q, mem_req_valid_d;
  logic [ADDR_WIDTH-1:0]     mem_req_addr_q, mem_req_addr_d;
  logic                      flush_done_q, flush_done_d;
  logic [ASSOCIATIVITY-1:0]  valid_q [NUM_SETS];
  logic [ASSOCIATIVITY-1:0]  valid_d [NUM_SETS];

  logic [TAG_BITS-1:0]       tag_mem  [NUM_SETS][ASSOCIATIVITY];
  logic [WORD_WIDTH-1:0]     data_mem [NUM_SETS][ASSOCIATIVITY][WORDS_PER_LINE];

  logic                      hit;
  logic [WAY_BITS-1:0]       hit_way;
  logic                      inv_found;
  logic [WAY_BITS-1:0]       inv_way;
  logic [WORD_WIDTH-1:0]     hit_word;
  logic [WAY_BITS-1:0]       plru_victim_way;
  logic [WAY_BITS-1:0]       miss_victim;
  logic                      data_we;
  logic                      tag_we;
  logic                      touch_en;
  logic [WAY_BITS-1:0]       touch_way;
  logic                      clr_en;
  logic                      unused_byte_bits;

  assign unused_byte_bits = ^req_addr[1:0];

  icache_plru #(
    .INDEX_BITS   (INDEX_BITS),
    .ASSOCIATIVITY(ASSOCIATIVITY),
    .WAY_BITS     (WAY_BITS)
  ) u_plru (
    .clk      (clk),
    .rst_n    (reset_n),
    .clr_en   (clr_en),
    .clr_idx  (flush_idx_q),
    .touch_en (touch_en),
    .touch_idx(req_idx_q),
    .touch_way(touch_way),
    .rd_idx   (req_idx_q),
    .victim   (plru_victim_way)
  );

  // Parallel tag compare; an invalid way is always preferred over the PLRU choice.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < ASSOCIATIVITY; w++) begin
      if (valid_q[req_idx_q][w] && (tag_mem[req_idx_q][w] == req_tag_q) && !hit) begin
        hit     = 1'b1;
        hit_way = WAY_BITS'(w);
      end
      if (!valid_q[req_idx_q][w] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = WAY_BITS'(w);
      end
    end
    hit_word    = data_mem[req_idx_q][hit_way][req_woff_q];
    miss_victim = inv_found ? inv_way : plru_victim_way;
  end

  always_comb begin
    state_d         = state_q;
    req_tag_d       = req_tag_q;
    req_idx_d       = req_idx_q;
    req_woff_d      = req_woff_q;
    victim_d        = victim_q;
    beat_cnt_d      = beat_cnt_q;
    flush_idx_d     = flush_idx_q;
    rsp_valid_d     = 1'b0;
    rsp_data_d      = rsp_data_q;
    rsp_hit_d       = rsp_hit_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_req_addr_d  = mem_req_addr_q;
    flush_done_d    = 1'b0;
    valid_d         = valid_q;
    data_we         = 1'b0;
    tag_we          = 1'b0;
    touch_en        = 1'b0;
    touch_way       = hit_way;
    clr_en          = 1'b0;
    // A flush seen while already flushing is covered by the flush in progress.
    flush_pending_d = flush_pending_q | (flush && (state_q != ST_FLUSH));

    case (state_q)
      ST_IDLE: begin
        if (flush || flush_pending_q) begin
          state_d         = ST_FLUSH;
          flush_pending_d = 1'b0;
          flush_idx_d     = '0;
        end else if (req_valid) begin
          req_tag_d  = req_addr[ADDR_WIDTH-1 -: TAG_BITS];
          req_idx_d  = req_addr[WOFF_BITS+2 +: INDEX_BITS];
          req_woff_d = req_addr[2 +: WOFF_BITS];
          state_d    = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (hit) begin
          rsp_valid_d = 1'b1;
          rsp_hit_d   = 1'b1;
          rsp_data_d  = hit_word;
          touch_en    = 1'b1;
          touch_way   = hit_way;
          state_d     = ST_IDLE;
        end else begin
          victim_d        = miss_victim;
          beat_cnt_d      = '0;
          mem_req_valid_d = 1'b1;
          mem_req_addr_d  = {req_tag_q, req_idx_q, {(WOFF_BITS + 2){1'b0}}};
          state_d         = ST_MISS_REQ;
        end
      end
      ST_MISS_REQ: begin
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          state_d         = ST_REFILL;
        end
      end
      ST_REFILL: begin
        if (mem_rsp_valid) begin
          data_we    = 1'b1;
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q == req_woff_q) begin
            rsp_data_d = mem_rsp_data;
          end
          if (beat_cnt_q == WOFF_BITS'(WORDS_PER_LINE - 1)) begin
            tag_we                      = 1'b1;
            valid_d[req_idx_q][victim_q] = 1'b1;
            touch_en                    = 1'b1;
            touch_way                   = victim_q;
            rsp_valid_d                 = 1'b1;
            rsp_hit_d                   = 1'b0;
            state_d                     = ST_RESPOND;
          end
        end
      end
      ST_RESPOND: begin
        state_d = ST_IDLE;
      end
      ST_FLUSH: begin
        clr_en               = 1'b1;
        valid_d[flush_idx_q] = '0;
        flush_idx_d          = flush_idx_q + 1'b1;
        if (flush_idx_q == '1) begin
          flush_done_d = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      victim_q        <= '0;
      beat_cnt_q      <= '0;
      flush_idx_q     <= '0;
      flush_pending_q <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_data_q      <= '0;
      rsp_hit_q       <= 1'b0;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
      flush_done_q    <= 1'b0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
      end
    end else begin
      state_q         <= state_d;
      victim_q        <= victim_d;
      beat_cnt_q      <= beat_cnt_d;
      flush_idx_q     <= flush_idx_d;
      flush_pending_q <= flush_pending_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_data_q      <= rsp_data_d;
      rsp_hit_q       <= rsp_hit_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_addr_q  <= mem_req_addr_d;
      flush_done_q    <= flush_done_d;
      valid_q         <= valid_d;
    end
  end

  // Request fields and the tag/data arrays carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    req_tag_q  <= req_tag_d;
    req_idx_q  <= req_idx_d;
    req_woff_q <= req_woff_d;
    if (data_we) begin
      data_mem[req_idx_q][victim_q][beat_cnt_q] <= mem_rsp_data;
    end
    if (tag_we) begin
      tag_mem[req_idx_q][victim_q] <= req_tag_q;
    end
  end

  assign req_ready     = reset_n && (state_q == ST_IDLE) && !flush && !flush_pending_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_hit       = rsp_hit_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign flush_done    = flush_done_q;

endmodule

// File: tb/tb_icache_sa_line_cache.sv
// Scoreboard bench for icache_sa_line_cache: directed fetches, refills,
// conflict eviction, memory stall, flush and mid-refill reset.
module tb_icache_sa_line_cache;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_hit;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        flush;
  logic        flush_done;

  int total = 0;
  int bad   = 0;
  logic [32:0] exp_q [$];

  icache_sa_line_cache dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_hit      (rsp_hit),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_addr (mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data (mem_rsp_data),
    .flush        (flush),
    .flush_done   (flush_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every response pulse is matched against the oldest expected entry.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", {31'd0, rsp_hit, rsp_data}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          chk("rsp_data", rsp_data, e[31:0]);
          chk("rsp_hit", rsp_hit, e[32]);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle", req_ready, 1);
  endtask

  task automatic send_req(input logic [31:0] addr);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", req_ready, 1);
    req_valid = 1'b1;
    req_addr  = addr;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic hit_txn(input logic [31:0] addr, input logic [31:0] word);
    exp_q.push_back({1'b1, word});
    send_req(addr);
    chk("hit_lookup_quiet", rsp_valid, 0);
    @(posedge clk);
    #1;
    chk("hit_latency", rsp_valid, 1);
    chk("hit_no_memreq", mem_req_valid, 0);
    wait_idle();
    chk("hit_no_memreq_after", mem_req_valid, 0);
  endtask

  task automatic wait_mem_req(input logic [31:0] line, input int stall);
    int n = 0;
    @(negedge clk);
    while (!mem_req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mem_req_valid", mem_req_valid, 1);
    chk("mem_req_addr", mem_req_addr, line);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_valid", mem_req_valid, 1);
      chk("stall_addr", mem_req_addr, line);
      chk("stall_ready", req_ready, 0);
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("mem_req_drop", mem_req_valid, 0);
  endtask

  task automatic miss_txn(input logic [31:0] addr, input logic [31:0] line, input logic [31:0] b0,
                          input int stall, input logic [31:0] word);
    exp_q.push_back({1'b0, word});
    send_req(addr);
    wait_mem_req(line, stall);
    for (int k = 0; k < 4; k++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = b0 + 32'(k);
      @(negedge clk);
    end
    mem_rsp_valid = 1'b0;
    wait_idle();
  endtask

  initial begin
    int lows;
    int dones;
    reset_n       = 1'b0;
    req_valid     = 1'b0;
    req_addr      = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    flush         = 1'b0;
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_outputs", {req_ready, rsp_hit, mem_req_valid, flush_done}, 0);
    chk("rst_data_addr", {rsp_data, mem_req_addr}, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", req_ready, 1);

    // Cold miss, then repeat hit.
    miss_txn(32'h0000_1234, 32'h0000_1230, 32'hA0, 0, 32'hA1);
    hit_txn(32'h0000_1234, 32'hA1);

    // Set 3 conflicts; second 0x3230-line fill stalls on mem_req_ready and asks for the last word.
    hit_txn(32'h0000_1230, 32'hA0);
    miss_txn(32'h0000_2230, 32'h0000_2230, 32'hC0, 0, 32'hC0);
    hit_txn(32'h0000_1230, 32'hA0);
    miss_txn(32'h0000_323C, 32'h0000_3230, 32'hD0, 5, 32'hD3);
    hit_txn(32'h0000_1230, 32'hA0);
    miss_txn(32'h0000_2230, 32'h0000_2230, 32'hE0, 0, 32'hE0);

    // Flush and request in the same idle cycle.
    wait_idle();
    flush     = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h0000_1234;
    #1;
    chk("flush_blocks_ready", req_ready, 0);
    @(negedge clk);
    flush     = 1'b0;
    req_valid = 1'b0;
    lows  = 0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (flush_done) dones++;
      if (req_ready) break;
      lows++;
      @(negedge clk);
    end
    @(negedge clk);
    if (flush_done) dones++;
    chk("flush_ready_low_cycles", 64'(lows), 16);
    chk("flush_done_pulses", 64'(dones), 1);
    chk("flush_no_memreq", mem_req_valid, 0);

    // Stray refill beats while idle must not disturb anything.
    for (int i = 0; i < 3; i++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'hDEAD_0000 + 32'(i);
      @(negedge clk);
    end
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("stray_rsp_data", rsp_data, 32'hE0);
    chk("stray_ready", req_ready, 1);
    miss_txn(32'h0000_1234, 32'h0000_1230, 32'hF0, 0, 32'hF1);

    // Reset after two of four refill beats.
    send_req(32'h0000_4234);
    wait_mem_req(32'h0000_4230, 0);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h90;
    @(negedge clk);
    mem_rsp_data  = 32'h91;
    @(negedge clk);
    mem_rsp_data  = 32'h92;
    reset_n       = 1'b0;
    #1;
    chk("midrst_mem_req", {mem_req_valid, mem_req_addr}, 0);
    chk("midrst_rsp", {rsp_valid, rsp_hit, rsp_data}, 0);
    chk("midrst_ready", req_ready, 0);
    @(negedge clk);
    reset_n      = 1'b1;
    mem_rsp_data = 32'h93;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("midrst_ignored_data", rsp_data, 0);
    chk("midrst_ignored_memreq", mem_req_valid, 0);
    miss_txn(32'h0000_1234, 32'h0000_1230, 32'hB0, 0, 32'hB1);
    hit_txn(32'h0000_1234, 32'hB1);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
